// File: rtl/series_engine_if.sv
// Handshake and coefficient-lookup signals of the series engine, grouped for port use.
// The slave side is the engine; the master side is the controller plus lookup.
interface series_engine_if;
    logic        start;
    logic [15:0] x_in;
    logic [15:0] rep_bus;
    logic [2:0]  rep_cnt;
    logic [15:0] result;
    logic        busy;
    logic        done;
    logic        ovf;

    modport master (
        output start, x_in, rep_bus,
        input  rep_cnt, result, busy, done, ovf
    );

    modport slave (
        input  start, x_in, rep_bus,
        output rep_cnt, result, busy, done, ovf
    );
endinterface

// File: rtl/series_engine.sv
// series_engine: Horner-form evaluator of an 8-term unsigned Q9.7 polynomial.
// Macro SERIES_SAT_EN: saturate sums at 0xFFFF with a sticky ovf flag; otherwise sums wrap.
module series_engine #(
    parameter int FRAC_BITS = 7,
    parameter int NTERMS    = 8
) (
    input  logic           clk,
    input  logic           rst,
    series_engine_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_HORNER = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      state_r;
    logic [15:0] acc_r;
    logic [15:0] x_r;
    logic [15:0] result_r;
    logic [2:0]  rep_cnt_r;
    logic        busy_r;
    logic        done_r;
    logic        ovf_r;
    logic        ovf_acc_r;

    logic [31:0] prod_s;
    logic [32:0] sum_s;
    logic [15:0] next_acc_s;
    logic        clip_s;

    assign prod_s = {16'd0, acc_r} * {16'd0, x_r};
    assign sum_s  = {1'b0, prod_s >> FRAC_BITS} + {17'd0, bus.rep_bus};

`ifdef SERIES_SAT_EN
    assign clip_s     = |sum_s[32:16];
    assign next_acc_s = clip_s ? 16'hFFFF : sum_s[15:0];
`else
    // Wrapping keeps only the low half; the upper sum bits are intentionally dropped.
    logic unused_sum_s;
    assign unused_sum_s = ^sum_s[32:16];
    assign clip_s       = 1'b0;
    assign next_acc_s   = sum_s[15:0];
`endif

    // Sequencer: the coefficient index doubles as the Horner step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            acc_r     <= 16'd0;
            x_r       <= 16'd0;
            result_r  <= 16'd0;
            rep_cnt_r <= 3'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ovf_r     <= 1'b0;
            ovf_acc_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        x_r       <= bus.x_in;
                        ovf_r     <= 1'b0;
                        ovf_acc_r <= 1'b0;
                        busy_r    <= 1'b1;
                        rep_cnt_r <= 3'(NTERMS - 1);
                        state_r   <= ST_LOAD;
                    end else begin
                        rep_cnt_r <= 3'd0;
                        state_r   <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    acc_r     <= bus.rep_bus;
                    rep_cnt_r <= rep_cnt_r - 3'd1;
                    state_r   <= ST_HORNER;
                end
                ST_HORNER: begin
                    acc_r     <= next_acc_s;
                    ovf_acc_r <= ovf_acc_r | clip_s;
                    if (rep_cnt_r == 3'd0) begin
                        result_r <= next_acc_s;
                        ovf_r    <= ovf_acc_r | clip_s;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= ST_DONE;
                    end else begin
                        rep_cnt_r <= rep_cnt_r - 3'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    rep_cnt_r <= 3'd0;
                end
            endcase
        end
    end

    assign bus.rep_cnt = rep_cnt_r;
    assign bus.result  = result_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.ovf     = ovf_r;
endmodule
